// File: rtl/gate_test_pkg.sv
// Shared types and the golden truth table for the two-input gate self-test sequencer.
package gate_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    localparam int NUM_VEC = 4;

    // Bit positions inside the {or,and,xor,xnor} result vector.
    localparam int RES_OR   = 3;
    localparam int RES_AND  = 2;
    localparam int RES_XOR  = 1;
    localparam int RES_XNOR = 0;

    function automatic logic [3:0] exp_gates(input logic a, input logic b);
        logic [3:0] r;
        r           = '0;
        r[RES_OR]   = a | b;
        r[RES_AND]  = a & b;
        r[RES_XOR]  = a ^ b;
        r[RES_XNOR] = ~(a ^ b);
        return r;
    endfunction

endpackage

// File: rtl/gate_test_seq.sv
// Self-test sequencer: sweeps the four {a,b} vectors through the gate datapath, waits a
// settle time, checks the results against the golden table and reports pass/errors.
module gate_test_seq
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int ITER       = 1,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_or,
    input  logic             dut_and,
    input  logic             dut_xor,
    input  logic             dut_xnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_fail_vec,
    output logic [3:0]       first_fail_res
);

    // Control strobes are level-sampled: start is accepted only in IDLE with abort low,
    // abort returns any non-IDLE state to IDLE on the next edge; neither is acknowledged.
    state_t           state, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [7:0]       iter_q, iter_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             a_q, a_d, b_q, b_d;
    logic             done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       ffv_q, ffv_d;
    logic [3:0]       ffr_q, ffr_d;
    logic [3:0]       res;
    logic             mismatch;

    assign res      = {dut_or, dut_and, dut_xor, dut_xnor};
    assign mismatch = (res != exp_gates(a_q, b_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            vec_q  <= '0;
            iter_q <= '0;
            cnt_q  <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            ffv_q  <= '0;
            ffr_q  <= '0;
        end else begin
            state  <= state_d;
            vec_q  <= vec_d;
            iter_q <= iter_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            done_q <= done_d;
            pass_q <= pass_d;
            err_q  <= err_d;
            ffv_q  <= ffv_d;
            ffr_q  <= ffr_d;
        end
    end

    always_comb begin
        state_d = state;
        vec_d   = vec_q;
        iter_d  = iter_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffr_d   = ffr_q;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_APPLY;
                    vec_d   = '0;
                    iter_d  = '0;
                    err_d   = '0;
                    ffv_d   = '0;
                    ffr_d   = '0;
                    pass_d  = 1'b0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end
            end
            ST_APPLY: begin
                cnt_d   = 8'(SETTLE_CYC);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    // err_cnt never returns to zero within a run, so zero marks the first miss.
                    if (err_q == '0) begin
                        ffv_d = {a_q, b_q};
                        ffr_d = res;
                    end
                end
                if (vec_q == 2'(NUM_VEC - 1)) begin
                    a_d = 1'b0;
                    b_d = 1'b0;
                    if (iter_q == 8'(ITER - 1)) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = ST_APPLY;
                        vec_d   = '0;
                        iter_d  = iter_q + 8'd1;
                    end
                end else begin
                    state_d    = ST_APPLY;
                    vec_d      = vec_q + 2'd1;
                    {a_d, b_d} = vec_q + 2'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && state != ST_IDLE) begin
            state_d = ST_IDLE;
            a_d     = 1'b0;
            b_d     = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = err_q;
            ffv_d   = ffv_q;
            ffr_d   = ffr_q;
        end
    end

    assign dut_a          = a_q;
    assign dut_b          = b_q;
    assign busy           = (state != ST_IDLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_res = ffr_q;

endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: two sequencer instances (default and ITER=3/ERR_W=3), each driving a
// gate model with injectable stuck-at faults, checked against a run-level reference model.
module tb_gate_test_seq;

    localparam int S   = 2;
    localparam int PER = S + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]      start_v, abort_v;
    logic [1:0]      a_v, b_v, busy_v, done_v, pass_v;
    logic [1:0][3:0] res_v, mask_v, val_v, err_v, ffr_v;
    logic [1:0][1:0] ffv_v;
    logic [3:0]      err0;
    logic [2:0]      err1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] golden(input logic a, input logic b);
        return {a | b, a & b, a ^ b, ~(a ^ b)};
    endfunction

    always_comb begin
        for (int u = 0; u < 2; u++)
            res_v[u] = (golden(a_v[u], b_v[u]) & ~mask_v[u]) | (val_v[u] & mask_v[u]);
    end

    assign err_v[0] = err0;
    assign err_v[1] = {1'b0, err1};

    gate_test_seq #(.SETTLE_CYC(S), .ITER(1), .ERR_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .dut_a(a_v[0]), .dut_b(b_v[0]),
        .dut_or(res_v[0][3]), .dut_and(res_v[0][2]), .dut_xor(res_v[0][1]), .dut_xnor(res_v[0][0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err0),
        .first_fail_vec(ffv_v[0]), .first_fail_res(ffr_v[0])
    );

    gate_test_seq #(.SETTLE_CYC(S), .ITER(3), .ERR_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .dut_a(a_v[1]), .dut_b(b_v[1]),
        .dut_or(res_v[1][3]), .dut_and(res_v[1][2]), .dut_xor(res_v[1][1]), .dut_xnor(res_v[1][0]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err1),
        .first_fail_vec(ffv_v[1]), .first_fail_res(ffr_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run-level model: counts mismatching vectors among the first nlimit sampled ones.
    task automatic ref_run(input int iter, input logic [3:0] mask, input logic [3:0] val,
                           input int errmax, input int nlimit,
                           output int e, output logic [1:0] fv, output logic [3:0] fr);
        int total = 0;
        fv = '0;
        fr = '0;
        for (int it = 0; it < iter; it++) begin
            for (int v = 0; v < 4; v++) begin
                logic [1:0] vb;
                logic [3:0] g, obs;
                vb = 2'(v);
                g = golden(vb[1], vb[0]);
                obs = (g & ~mask) | (val & mask);
                if (it * 4 + v < nlimit && obs != g) begin
                    if (total == 0) begin
                        fv = vb;
                        fr = obs;
                    end
                    total++;
                end
            end
        end
        e = (total > errmax) ? errmax : total;
    endtask

    task automatic check_idle_outputs(input int u, input string tag);
        check({tag, "_busy"}, busy_v[u], 1'b0);
        check({tag, "_done"}, done_v[u], 1'b0);
        check({tag, "_a"}, a_v[u], 1'b0);
        check({tag, "_b"}, b_v[u], 1'b0);
    endtask

    // Pulses start so it is seen at edge E0, then returns #1 after E0 (t=0).
    task automatic start_run(input int u);
        @(posedge clk);
        #1 start_v[u] = 1'b1;
        @(posedge clk);
        #1 start_v[u] = 1'b0;
    endtask

    task automatic run(input int u, input int iter, input int errmax, input bit restarts,
                       input int abort_at);
        int total, e, nlim;
        logic [1:0] fv;
        logic [3:0] fr;
        total = 4 * PER * iter;
        nlim = (abort_at >= 0) ? abort_at / PER : 4 * iter;
        ref_run(iter, mask_v[u], val_v[u], errmax, nlim, e, fv, fr);
        start_run(u);
        for (int t = 0; t <= total + 1; t++) begin
            int vec;
            logic [1:0] vb;
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (abort_at >= 0 && t == abort_at + 1) begin
                abort_v[u] = 1'b0;
                start_v[u] = 1'b0;
                check_idle_outputs(u, "abort");
                check("abort_pass", pass_v[u], 1'b0);
                check("abort_err", err_v[u], 32'(e));
                check("abort_ffv", ffv_v[u], fv);
                check("abort_ffr", ffr_v[u], fr);
                repeat (PER * 2) begin
                    @(posedge clk);
                    #1 check_idle_outputs(u, "post_abort");
                end
                return;
            end
            vec = (t / PER) % 4;
            vb = 2'(vec);
            if (t < total) begin
                check("busy", busy_v[u], 1'b1);
                check("done_low", done_v[u], 1'b0);
                check("dut_a", a_v[u], vb[1]);
                check("dut_b", b_v[u], vb[0]);
            end else if (t == total) begin
                check("fin_done", done_v[u], 1'b1);
                check("fin_busy", busy_v[u], 1'b1);
                check("fin_a", a_v[u], 1'b0);
                check("fin_b", b_v[u], 1'b0);
                check("fin_pass", pass_v[u], (e == 0));
                check("fin_err", err_v[u], 32'(e));
                check("fin_ffv", ffv_v[u], fv);
                check("fin_ffr", ffr_v[u], fr);
            end else begin
                check_idle_outputs(u, "after");
                check("hold_pass", pass_v[u], (e == 0));
                check("hold_err", err_v[u], 32'(e));
            end
            if (restarts) start_v[u] = (t == 5 || t == 9);
            if (t == abort_at) abort_v[u] = 1'b1;
        end
        start_v[u] = 1'b0;
    endtask

    initial begin
        start_v = '0;
        abort_v = '0;
        mask_v  = '0;
        val_v   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check_idle_outputs(u, "reset");
            check("reset_pass", pass_v[u], 1'b0);
            check("reset_err", err_v[u], 0);
            check("reset_ffv", ffv_v[u], 0);
            check("reset_ffr", ffr_v[u], 0);
        end
        @(negedge clk) rst_n = 1'b1;

        // Fault-free sweep.
        run(0, 1, 15, 1'b0, -1);
        // XOR output stuck at 0.
        mask_v[0] = 4'b0010;
        val_v[0]  = 4'b0000;
        run(0, 1, 15, 1'b0, -1);
        check("xor_ffr_const", ffr_v[0], 4'b1000);
        check("xor_err_const", err_v[0], 2);
        // Abort mid-run, then a clean run.
        mask_v[0] = '0;
        run(0, 1, 15, 1'b0, 6);
        run(0, 1, 15, 1'b0, -1);
        // Restart pulses while busy are ignored.
        run(0, 1, 15, 1'b1, -1);

        // Asynchronous reset in the middle of a cycle.
        start_run(0);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "async_rst");
        check("async_rst_pass", pass_v[0], 1'b0);
        check("async_rst_err", err_v[0], 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1 check_idle_outputs(0, "rst_release");
        end

        // Three sweeps, AND stuck at 1, 3-bit saturating counter.
        mask_v[1] = 4'b0100;
        val_v[1]  = 4'b0100;
        run(1, 3, 7, 1'b0, -1);
        check("sat_err_const", err_v[1], 7);
        check("sat_ffr_const", ffr_v[1], 4'b0101);

        // Randomized runs with random faults, restarts and aborts.
        repeat (24) begin
            int u, iter, errmax, ab;
            bit rs;
            u = $urandom_range(0, 1);
            iter = (u == 0) ? 1 : 3;
            errmax = (u == 0) ? 15 : 7;
            mask_v[u] = 4'($urandom_range(0, 15));
            val_v[u] = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * PER * iter - 1)) : -1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run(u, iter, errmax, rs, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gate_test_seq.md
Name: gate_test_seq

Overview:
Self-test sequencer for the two-input logic-gate datapath with OR/AND/XOR/XNOR outputs. On a start pulse it drives the gate inputs through all four input vectors and waits a programmable settle time. It then samples the four gate outputs and compares them against a golden truth table. It reports pass/fail, an error count and the first failing vector. It sits between the board-level control (button/CPU strobe) and the gate datapath it exercises.

Parameters:
SETTLE_CYC, 2, cycles held in WAIT between driving a vector and sampling (legal range 1..255)
ITER, 1, number of full 4-vector sweeps per run (legal range 1..255)
ERR_W, 4, width of the saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  terminate a run; return to IDLE
dut_a  output  1  gate input a (registered)
dut_b  output  1  gate input b (registered)
dut_or  input  1  gate OR result
dut_and  input  1  gate AND result
dut_xor  input  1  gate XOR result
dut_xnor  input  1  gate XNOR result
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at successful end of run
pass  output  1  1 = last completed run had zero mismatches
err_cnt  output  ERR_W  number of mismatching vectors, saturating
first_fail_vec  output  2  index {a,b} of first mismatching vector
first_fail_res  output  4  captured {or,and,xor,xnor} at first mismatch

Behaviour:
- One clock domain (clk). rst_n is asynchronous and active-low. While rst_n=0, all outputs and all state are 0 and the FSM is in IDLE.
- States: IDLE, APPLY, WAIT, SAMPLE, FINISH. All outputs are registered.
- IDLE: start=1 and abort=0 at edge E0 -> APPLY. The same edge clears err_cnt, first_fail_*, pass, vector index and iteration count.
- APPLY (1 cycle): dut_a=vec[1], dut_b=vec[0]. Load settle counter with SETTLE_CYC -> WAIT.
- WAIT: counter decrements each cycle. Exit to SAMPLE after exactly SETTLE_CYC cycles in WAIT.
- SAMPLE (1 cycle): compare {dut_or,dut_and,dut_xor,dut_xnor} to the expected value {a|b, a&b, a^b, ~(a^b)}.
  - On mismatch: err_cnt+1, saturating at 2^ERR_W-1.
  - On the first mismatch of the run: latch first_fail_vec and first_fail_res.
- After SAMPLE:
  - If vec=3 and iter=ITER-1 -> FINISH.
  - Else if vec=3: vec=0, iter+1 -> APPLY.
  - Else: vec+1 -> APPLY.
- Vector order: 00, 01, 10, 11. dut_a/dut_b hold their value from APPLY through SAMPLE and are 0 in IDLE and FINISH.
- Timing: each vector takes SETTLE_CYC+2 cycles. The FSM enters FINISH at edge E0 + 4*(SETTLE_CYC+2)*ITER.
- FINISH (1 cycle): done=1 and pass=(err_cnt==0), then -> IDLE. done is 0 in all other states.
- pass, err_cnt and first_fail_* hold their values until the next accepted start. first_fail_* stay 0 if there is no mismatch.
- start while busy: ignored; no restart, no queueing.
- abort in any non-IDLE state (including FINISH): -> IDLE at next edge. No done pulse, pass=0, dut_a/dut_b=0. err_cnt and first_fail_* keep their partial values.
- abort and start both high in IDLE: abort wins; stay in IDLE.
- rst_n asserted mid-run: immediate return to the reset state. After release, stay in IDLE until a new start.

Decomposition:
- Package gate_test_pkg holds:
  - the state enum,
  - NUM_VEC=4,
  - the golden function exp_gates(a,b) returning 4 bits in {or,and,xor,xnor} order,
  - the bit-position constants for the result vector.
- No sub-module is needed. The settle counter, vector/iteration counters and compare logic stay inline in gate_test_seq.

Test Plan:
1. Defaults, fault-free gate model attached; start pulse at E0 -> busy=1 from E0; vectors 00,01,10,11 each held 4 cycles; done high for one cycle after E0+16; pass=1, err_cnt=0, first_fail_vec=0, first_fail_res=0.
2. dut_xor stuck-at-0 -> mismatches on vectors 01 and 10; err_cnt=2; first_fail_vec=2'b01; first_fail_res=4'b1000 (expected 4'b1010); pass=0.
3. abort asserted at E0+6 -> IDLE at the next edge; busy=0, dut_a=dut_b=0, no done pulse, pass=0; a fresh start then completes with pass=1.
4. start re-pulsed at E0+5 and E0+9 -> ignored; exactly one done pulse, after E0+16.
5. rst_n driven low at E0+9 (asynchronously, mid-cycle) -> all outputs 0 before the next edge; after release, busy stays 0 until a new start.
6. ITER=3, ERR_W=3, dut_and stuck-at-1 -> 3 mismatches per sweep (vectors 00,01,10); err_cnt saturates at 7 (not 9); first_fail_vec=0, first_fail_res=4'b0101; done after E0+48; pass=0.
